pwm_multi: RTL

- Multi-channel PWM generator on the 8-bit CSR bus, parametrised in channel count.
- All channels share one prescaler and one period counter, so their edges are phase-aligned.
- Duty cycle, period and polarity are programmable per channel or globally as listed below.
- Period and duty values are double-buffered and applied only at period boundaries, so updates never produce a glitch pulse.
- Drives fan PWM and backlight pins. Emits a per-period strobe for the interrupt block.

---
 rtl/pwm_pkg.sv | 35 +++
 rtl/pwm_multi_if.sv | 18 +
 rtl/pwm_chan.sv | 80 ++++++++
 rtl/pwm_multi.sv | 123 ++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module : pwm_pkg
// Brief  : Shared register offsets, bit positions, reset constants and
//          helpers for the multi-channel PWM block.
// Rev    : 1.0  initial release
// ============================================================================
package pwm_pkg;

  // Register offsets relative to BASE_ADDR
  localparam logic [4:0] GCTRL_OFS  = 5'd0;
  localparam logic [4:0] PERIOD_OFS = 5'd1;

  // Bit positions inside GCTRL / CHCTRLn
  localparam int RUN_BIT = 7;
  localparam int EN_BIT  = 7;
  localparam int INV_BIT = 6;

  localparam logic [7:0] PERIOD_RST = 8'hFF;

  // Channel n occupies CHCTRL at CH_OFS(n) and DUTY at CH_OFS(n)+1
  function automatic logic [4:0] CH_OFS(input int unsigned n);
    return 5'(2 + 2 * n);
  endfunction

  // Low-bit mask of the prescaler counter that must be all ones for a tick.
  // prescale=0 yields an empty mask, so every pwm_ce becomes a tick.
  function automatic logic [6:0] pre_mask(input logic [2:0] prescale);
    logic [7:0] m;
    m = (8'd1 << prescale) - 8'd1;
    return m[6:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_multi_if.sv
`default_nettype none
// ============================================================================
// Module : pwm_multi_if
// Brief  : 8-bit CSR bus bundle.
//          csr_a  : address        csr_di : write data
//          csr_we : write strobe   csr_do : combinational read data
// Rev    : 1.0  initial release
// ============================================================================
interface pwm_multi_if;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;

  modport master (output csr_a, output csr_di, output csr_we, input csr_do);
  modport slave  (input csr_a, input csr_di, input csr_we, output csr_do);
endinterface
`default_nettype wire

// File: rtl/pwm_chan.sv
`default_nettype none
// ============================================================================
// Module : pwm_chan
// Brief  : One PWM channel: CHCTRL/DUTY registers, duty shadow, compare
//          against the shared period counter and registered output pin.
//   clk, rst            : clock, synchronous active-high reset
//   csr_a/csr_di/csr_we : CSR write side
//   csr_do              : this channel's read contribution (0 if not hit)
//   cnt                 : shared period counter
//   wrap_load           : shadow load strobe (wrap tick or run=0)
//   run                 : global run bit; idle level when clear
//   pwm_out, pwm_en     : registered pin and enable bit
// Rev    : 1.0  initial release
// ============================================================================
module pwm_chan
  import pwm_pkg::*;
#(
  parameter logic [4:0] CTRL_ADDR = 5'd2,
  parameter logic [4:0] DUTY_ADDR = 5'd3
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic [4:0] csr_a,
  input  wire logic [7:0] csr_di,
  input  wire logic       csr_we,
  output logic      [7:0] csr_do,
  input  wire logic [7:0] cnt,
  input  wire logic       wrap_load,
  input  wire logic       run,
  output logic            pwm_out,
  output logic            pwm_en
);

  logic       r_en;
  logic       r_inv;
  logic [7:0] r_duty;
  logic [7:0] r_duty_act;
  logic       r_out;
  logic       w_raw;

  assign w_raw = (cnt < r_duty_act);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en       <= 1'b0;
      r_inv      <= 1'b0;
      r_duty     <= 8'h00;
      r_duty_act <= 8'h00;
      r_out      <= 1'b0;
    end else begin
      if (csr_we && csr_a == CTRL_ADDR) begin
        r_en  <= csr_di[EN_BIT];
        r_inv <= csr_di[INV_BIT];
      end
      if (csr_we && csr_a == DUTY_ADDR) begin
        r_duty <= csr_di;
      end
      // Shadow samples the pre-write register, so a write coinciding with
      // a wrap only takes effect one period later.
      if (wrap_load) begin
        r_duty_act <= r_duty;
      end
      r_out <= (run && r_en) ? (w_raw ^ r_inv) : r_inv;
    end
  end

  always_comb begin
    csr_do = 8'h00;
    if (csr_a == CTRL_ADDR) begin
      csr_do = {r_en, r_inv, 6'b0};
    end else if (csr_a == DUTY_ADDR) begin
      csr_do = r_duty;
    end
  end

  assign pwm_out = r_out;
  assign pwm_en  = r_en;

endmodule
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// Module : pwm_multi
// Brief  : Multi-channel phase-aligned PWM generator on the 8-bit CSR bus.
//          Shared prescaler and period counter; per-channel duty/enable/
//          polarity; period and duty double-buffered at period wraps.
//   clk, rst   : clock, synchronous active-high reset
//   csr        : CSR bus (slave)
//   pwm_ce     : base tick enable
//   pwm_en     : per-channel enable bits
//   pwm_out    : registered PWM pins
//   period_stb : one-clk pulse at each period wrap
// Rev    : 1.0  initial release
// ============================================================================
module pwm_multi
  import pwm_pkg::*;
#(
  parameter logic [4:0] BASE_ADDR = 5'h0,
  parameter int         CHANNELS  = 4
) (
  input  wire logic                clk,
  input  wire logic                rst,
  pwm_multi_if.slave               csr,
  input  wire logic                pwm_ce,
  output logic      [CHANNELS-1:0] pwm_en,
  output logic      [CHANNELS-1:0] pwm_out,
  output logic                     period_stb
);

  logic       r_run;
  logic [2:0] r_ps;
  logic [7:0] r_period;
  logic [7:0] r_per_act;
  logic [6:0] r_pre;
  logic [7:0] r_cnt;
  logic       r_stb;

  logic [6:0] w_mask;
  logic       w_tick;
  logic       w_wrap;
  logic       w_load;
  logic [7:0] w_rd;
  logic [7:0] w_chan_do [CHANNELS];

  assign w_mask = pre_mask(r_ps);
  assign w_tick = r_run && pwm_ce && ((r_pre & w_mask) == w_mask);
  assign w_wrap = w_tick && (r_cnt == r_per_act);
  // While stopped the shadows track the registers so a restart is current.
  assign w_load = !r_run || w_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run     <= 1'b0;
      r_ps      <= 3'd0;
      r_period  <= PERIOD_RST;
      r_per_act <= PERIOD_RST;
      r_pre     <= 7'd0;
      r_cnt     <= 8'd0;
      r_stb     <= 1'b0;
    end else begin
      if (csr.csr_we && csr.csr_a == BASE_ADDR + GCTRL_OFS) begin
        r_run <= csr.csr_di[RUN_BIT];
        r_ps  <= csr.csr_di[2:0];
      end
      if (csr.csr_we && csr.csr_a == BASE_ADDR + PERIOD_OFS) begin
        r_period <= csr.csr_di;
      end
      if (w_load) begin
        r_per_act <= r_period;
      end
      if (!r_run) begin
        r_pre <= 7'd0;
        r_cnt <= 8'd0;
        r_stb <= 1'b0;
      end else begin
        if (pwm_ce) begin
          r_pre <= r_pre + 7'd1;
        end
        if (w_tick) begin
          r_cnt <= w_wrap ? 8'd0 : r_cnt + 8'd1;
        end
        r_stb <= w_wrap;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pwm_chan #(
      .CTRL_ADDR(BASE_ADDR + CH_OFS(i)),
      .DUTY_ADDR(BASE_ADDR + CH_OFS(i) + 5'd1)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .csr_a    (csr.csr_a),
      .csr_di   (csr.csr_di),
      .csr_we   (csr.csr_we),
      .csr_do   (w_chan_do[i]),
      .cnt      (r_cnt),
      .wrap_load(w_load),
      .run      (r_run),
      .pwm_out  (pwm_out[i]),
      .pwm_en   (pwm_en[i])
    );
  end

  // Each source drives zero when not addressed, so an OR is the read mux.
  always_comb begin
    w_rd = 8'h00;
    if (csr.csr_a == BASE_ADDR + GCTRL_OFS) begin
      w_rd = {r_run, 4'b0, r_ps};
    end else if (csr.csr_a == BASE_ADDR + PERIOD_OFS) begin
      w_rd = r_period;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      w_rd = w_rd | w_chan_do[i];
    end
  end

  assign csr.csr_do = w_rd;
  assign period_stb = r_stb;

endmodule
`default_nettype wire
